dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (addr / write-data / 4-bit byte write-enable / read-data) between the CPU memory stage and one auxiliary master (debug/DMA loader).
- Sits between mem_module's Zz_* / zZ_din signals and the dmem RAM.
- Grants the port per cycle, stalls the loser, supports locked auxiliary bursts and tags the 1-cycle-latency read return to its owner.

Parameters:
- AUX_WAIT_MAX, 8: cycles a pending aux request may be refused before it is forced through (only with the optional feature).
- CNT_W, 4: starvation counter width. Must satisfy 2^CNT_W > AUX_WAIT_MAX.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active low
- cpu_req  in  1  CPU memory-stage access request
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data, already lane-replicated
- cpu_wr_en  in  4  CPU byte write enables; 0 means read
- cpu_stall  out  1  CPU access refused this cycle; pipeline must hold
- cpu_rdata  out  32  read data to CPU
- cpu_rvalid  out  1  cpu_rdata valid for the CPU read granted last cycle
- aux_req  in  1  aux access request; held until granted
- aux_lock  in  1  aux requests port ownership for following cycles (burst)
- aux_addr  in  32  aux byte address
- aux_wdata  in  32  aux write data
- aux_wr_en  in  4  aux byte write enables; 0 means read
- aux_gnt  out  1  aux access performed this cycle
- aux_rdata  out  32  read data to aux
- aux_rvalid  out  1  aux_rdata valid for the aux read granted last cycle
- mem_addr  out  32  to RAM address
- mem_dout  out  32  to RAM write data
- mem_wr_en  out  4  to RAM byte write enables
- mem_din  in  32  RAM read data, valid 1 cycle after the address

Behaviour:
- Reset is synchronous, active low: state=ST_CPU, cpu_rvalid=0, aux_rvalid=0, rd_owner=NONE, starvation counter=0.
- Reset mid-burst returns to ST_CPU and drops any pending rvalid.
- Grant logic is combinational from state and requests.
- cpu_gnt is internal; aux_gnt is an output.
- ST_CPU:
  - Grant CPU if cpu_req and not force_aux.
  - Else grant aux if aux_req.
  - Aux granted with aux_lock=1 -> next state ST_AUX; otherwise stay.
- ST_AUX:
  - Aux owns the port; CPU is never granted.
  - aux_req & aux_lock: grant aux, stay.
  - aux_req & !aux_lock: grant aux as the final beat, next state ST_CPU.
  - !aux_req: evaluate as in ST_CPU in the same cycle, so the CPU may be granted; next state ST_CPU.
- Port mux:
  - Granted master drives mem_addr, mem_dout and mem_wr_en.
  - No grant: mem_addr=0, mem_dout=0, mem_wr_en=4'b0000.
- Stall signals:
  - cpu_stall = cpu_req & !cpu_gnt.
  - aux_gnt = aux_req & aux granted.
- Read return:
  - rd_owner is registered each cycle as CPU, AUX or NONE.
  - A read is a granted access with wr_en==0; a granted write registers NONE.
  - cpu_rvalid = (rd_owner==CPU) and aux_rvalid = (rd_owner==AUX), both registered.
  - cpu_rdata = aux_rdata = mem_din, unregistered passthrough.
- Writes complete in the grant cycle; no response is generated.
- Simultaneous cpu_req & aux_req in ST_CPU: the CPU wins unless force_aux.
- Back-to-back reads from alternating owners are legal. Each rvalid follows its own grant by exactly 1 cycle.

Optional Feature:
- Macro: DMEM_ARB_STARVE_GUARD_EN.
- Defined:
  - CNT_W-bit counter increments each cycle aux_req & !aux_gnt, saturating at AUX_WAIT_MAX.
  - Counter clears on aux_gnt.
  - force_aux = (counter==AUX_WAIT_MAX) & aux_req, which overrides CPU priority for one grant.
- Undefined:
  - No counter; force_aux=0.
  - Strict CPU priority; aux can starve indefinitely under continuous cpu_req.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both reqs high -> all rvalids 0, mem_wr_en=0 during reset; first cycle after release grants CPU.
- CPU read: cpu_req=1, cpu_addr=0x00000010, cpu_wr_en=0, RAM returns 0xDEADBEEF -> mem_addr=0x10 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, aux_rvalid=0.
- Contention: both req, aux write 0x00000020/wr_en=4'b1111 -> CPU granted, aux_gnt=0; CPU drops req -> aux granted next cycle with mem_wr_en=4'b1111, cpu_stall=0.
- Locked burst: aux 3 reads with aux_lock=1,1,0 while cpu_req=1 -> cpu_stall=1 for all 3 cycles, aux_rvalid pulses 3 times offset by 1 cycle, CPU granted on cycle 4.
- Starvation (macro defined, AUX_WAIT_MAX=8): cpu_req held high, aux_req high -> aux_gnt=1 on the 9th cycle, cpu_stall=1 that cycle, counter back to 0. With the macro undefined -> aux_gnt stays 0 for 50 cycles.
- Reset mid-burst: rst=0 while in ST_AUX with a read outstanding -> aux_rvalid=0 next cycle; after release a CPU request is granted immediately.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single data-memory port between the CPU memory stage and one
// auxiliary master (debug / DMA loader).
//  - The CPU has priority in ST_CPU; the aux master can lock the port for a burst (ST_AUX).
//  - The grant is combinational from the current state and the requests.
//  - Read data comes back one cycle later. A registered read-owner tag steers
//    cpu_rvalid / aux_rvalid.
// Optional feature, enabled by defining DMEM_ARB_STARVE_GUARD_EN:
//  - A starvation counter forces one aux grant after AUX_WAIT_MAX refused cycles.
//  - Without the macro the CPU has strict priority, and the aux master may wait forever.
`timescale 1ns/1ps

module dmem_port_arbiter #(
    parameter int AUX_WAIT_MAX = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wr_en,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,

    input  logic        aux_req,
    input  logic        aux_lock,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic [3:0]  aux_wr_en,
    output logic        aux_gnt,
    output logic [31:0] aux_rdata,
    output logic        aux_rvalid,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_dout,
    output logic [3:0]  mem_wr_en,
    input  logic [31:0] mem_din
);

    typedef enum logic {
        ST_CPU,
        ST_AUX
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_AUX
    } owner_t;

    state_t state;
    state_t next_state;
    owner_t rd_owner;
    owner_t next_owner;

    logic   cpu_gnt;
    logic   aux_sel;
    logic   force_aux;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(AUX_WAIT_MAX);

    logic [CNT_W-1:0] starve_cnt;

    assign force_aux = (starve_cnt == WAIT_LIMIT) && aux_req;

    // Count cycles a pending aux request is refused. Saturate at the limit, and clear on any aux grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (aux_gnt) begin
            starve_cnt <= '0;
        end else if (aux_req && (starve_cnt != WAIT_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_wait_limit;

    assign force_aux         = 1'b0;
    assign unused_wait_limit = CNT_W'(AUX_WAIT_MAX);
`endif

    // Decide who owns the port this cycle and where the FSM goes next; nobody is granted while reset is held so no stray write reaches the RAM.
    always_comb begin
        cpu_gnt    = 1'b0;
        aux_sel    = 1'b0;
        next_state = state;
        if (rst) begin
            case (state)
                ST_CPU: begin
                    if (cpu_req && !force_aux) begin
                        cpu_gnt = 1'b1;
                    end else if (aux_req) begin
                        aux_sel    = 1'b1;
                        next_state = aux_lock ? ST_AUX : ST_CPU;
                    end
                end
                ST_AUX: begin
                    next_state = ST_CPU;
                    if (aux_req) begin
                        aux_sel = 1'b1;
                        if (aux_lock) begin
                            next_state = ST_AUX;
                        end
                    end else if (cpu_req && !force_aux) begin
                        cpu_gnt = 1'b1;
                    end
                end
                default: begin
                    next_state = ST_CPU;
                end
            endcase
        end
    end

    assign aux_gnt   = aux_req & aux_sel;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Steer the granted master onto the RAM port; an idle port presents all zeros.
    always_comb begin
        mem_addr  = '0;
        mem_dout  = '0;
        mem_wr_en = 4'b0000;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_dout  = cpu_wdata;
            mem_wr_en = cpu_wr_en;
        end else if (aux_gnt) begin
            mem_addr  = aux_addr;
            mem_dout  = aux_wdata;
            mem_wr_en = aux_wr_en;
        end
    end

    // Tag which master issued a read this cycle so its data can be claimed next cycle; writes complete silently.
    always_comb begin
        next_owner = OWN_NONE;
        if (cpu_gnt && (cpu_wr_en == 4'b0000)) begin
            next_owner = OWN_CPU;
        end else if (aux_gnt && (aux_wr_en == 4'b0000)) begin
            next_owner = OWN_AUX;
        end
    end

    // Arbitration state and read-owner tag; reset drops any burst and any read still in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_CPU;
            rd_owner <= OWN_NONE;
        end else begin
            state    <= next_state;
            rd_owner <= next_owner;
        end
    end

    assign cpu_rvalid = (rd_owner == OWN_CPU);
    assign aux_rvalid = (rd_owner == OWN_AUX);
    assign cpu_rdata  = mem_din;
    assign aux_rdata  = mem_din;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// The test sequence runs in this order:
//  - Reset, then release.
//  - A table of single-cycle vectors. Each vector holds the inputs and the expected port mux, stall and grant values, plus the read-return flags from the previous vector.
//  - Hand-written sequences for the locked burst, the early burst exit, starvation, and reset during a burst.
// Starvation expectations depend on DMEM_ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps

module tb_dmem_port_arbiter;

    localparam logic [31:0] CW = 32'h1111_1111;
    localparam logic [31:0] AW = 32'h2222_2222;
    localparam int          NV = 14;

    typedef struct {
        logic        cpu_req;
        logic [31:0] cpu_addr;
        logic [3:0]  cpu_wr_en;
        logic        aux_req;
        logic        aux_lock;
        logic [31:0] aux_addr;
        logic [3:0]  aux_wr_en;
        logic [31:0] mem_din;
        logic        e_stall;
        logic        e_gnt;
        logic [31:0] e_addr;
        logic [31:0] e_dout;
        logic [3:0]  e_wr;
        logic        e_crv;
        logic        e_arv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wr_en;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        aux_req;
    logic        aux_lock;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic [3:0]  aux_wr_en;
    logic        aux_gnt;
    logic [31:0] aux_rdata;
    logic        aux_rvalid;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [3:0]  mem_wr_en;
    logic [31:0] mem_din;

    int checks = 0;
    int passed = 0;

    vec_t tbl [NV];

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .AUX_WAIT_MAX (8),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .aux_req    (aux_req),
        .aux_lock   (aux_lock),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_wr_en  (aux_wr_en),
        .aux_gnt    (aux_gnt),
        .aux_rdata  (aux_rdata),
        .aux_rvalid (aux_rvalid),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_wr_en  (mem_wr_en),
        .mem_din    (mem_din)
    );

    // Compare a vector-valued output against its required value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Compare a single-bit output against its required value
    task automatic checkFlag(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    // Drive one table vector onto the DUT inputs
    task automatic applyStimulus(input vec_t v);
        cpu_req   = v.cpu_req;
        cpu_addr  = v.cpu_addr;
        cpu_wr_en = v.cpu_wr_en;
        aux_req   = v.aux_req;
        aux_lock  = v.aux_lock;
        aux_addr  = v.aux_addr;
        aux_wr_en = v.aux_wr_en;
        mem_din   = v.mem_din;
    endtask

    // Return all request inputs to idle
    task automatic setIdle();
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_wr_en = 4'h0;
        aux_req   = 1'b0;
        aux_lock  = 1'b0;
        aux_addr  = '0;
        aux_wr_en = 4'h0;
        mem_din   = '0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every output listed in a table row
    task automatic checkRow(input int i, input vec_t v);
        checkFlag  ($sformatf("row%0d cpu_stall", i),  cpu_stall,       v.e_stall);
        checkFlag  ($sformatf("row%0d aux_gnt", i),    aux_gnt,         v.e_gnt);
        checkOutput($sformatf("row%0d mem_addr", i),   mem_addr,        v.e_addr);
        checkOutput($sformatf("row%0d mem_dout", i),   mem_dout,        v.e_dout);
        checkOutput($sformatf("row%0d mem_wr_en", i),  32'(mem_wr_en),  32'(v.e_wr));
        checkFlag  ($sformatf("row%0d cpu_rvalid", i), cpu_rvalid,      v.e_crv);
        checkFlag  ($sformatf("row%0d aux_rvalid", i), aux_rvalid,      v.e_arv);
        checkOutput($sformatf("row%0d cpu_rdata", i),  cpu_rdata,       v.mem_din);
        checkOutput($sformatf("row%0d aux_rdata", i),  aux_rdata,       v.mem_din);
    endtask

    initial begin
        int grants;
        int stalls_missing;

        //              creq  caddr          cwr   areq  alock aaddr          awr   din             stall gnt   addr           dout wr    crv   arv
        tbl[0]  = '{1'b1, 32'h0000_0010, 4'h0, 1'b0, 1'b0, 32'h0,         4'h0, 32'h0,          1'b0, 1'b0, 32'h0000_0010, CW,   4'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         4'h0, 1'b0, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEEF,  1'b0, 1'b0, 32'h0,         32'h0, 4'h0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0030, 4'h0, 1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0,          1'b0, 1'b0, 32'h0000_0030, CW,   4'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0,          1'b0, 1'b1, 32'h0000_0020, AW,   4'hF, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,         4'h0, 1'b0, 1'b0, 32'h0,         4'h0, 32'h0,          1'b0, 1'b0, 32'h0,         32'h0, 4'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h0000_0040, 4'h3, 1'b0, 1'b0, 32'h0,         4'h0, 32'h0,          1'b0, 1'b0, 32'h0000_0040, CW,   4'h3, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0000_0050, 4'h0, 32'h0,          1'b0, 1'b1, 32'h0000_0050, AW,   4'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 32'h0000_0060, 4'h0, 1'b1, 1'b0, 32'h0000_0070, 4'h0, 32'hCAFE_F00D,  1'b0, 1'b0, 32'h0000_0060, CW,   4'h0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0000_0070, 4'h0, 32'h1234_5678,  1'b0, 1'b1, 32'h0000_0070, AW,   4'h0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0080, 4'h0, 1'b0, 1'b0, 32'h0,         4'h0, 32'hA5A5_A5A5,  1'b0, 1'b0, 32'h0000_0080, CW,   4'h0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 32'h0,         4'h0, 1'b0, 1'b0, 32'h0,         4'h0, 32'h5A5A_5A5A,  1'b0, 1'b0, 32'h0,         32'h0, 4'h0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 32'h0000_0090, 4'h0, 1'b1, 1'b1, 32'h0000_00A0, 4'h0, 32'h0,          1'b0, 1'b0, 32'h0000_0090, CW,   4'h0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0000_00A0, 4'h0, 32'h0,          1'b0, 1'b1, 32'h0000_00A0, AW,   4'h0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 32'h0000_00B0, 4'h0, 1'b0, 1'b0, 32'h0,         4'h0, 32'h7777_0000,  1'b0, 1'b0, 32'h0000_00B0, CW,   4'h0, 1'b0, 1'b1};

        // Reset held with both masters requesting writes
        rst       = 1'b0;
        cpu_wdata = CW;
        aux_wdata = AW;
        cpu_req   = 1'b1;
        cpu_addr  = 32'h0000_0100;
        cpu_wr_en = 4'hF;
        aux_req   = 1'b1;
        aux_lock  = 1'b1;
        aux_addr  = 32'h0000_0104;
        aux_wr_en = 4'hF;
        mem_din   = '0;
        tick();
        for (int i = 0; i < 2; i++) begin
            #3;
            checkOutput($sformatf("reset%0d mem_wr_en", i), 32'(mem_wr_en), 32'h0);
            checkFlag  ($sformatf("reset%0d cpu_rvalid", i), cpu_rvalid, 1'b0);
            checkFlag  ($sformatf("reset%0d aux_rvalid", i), aux_rvalid, 1'b0);
            checkFlag  ($sformatf("reset%0d aux_gnt", i), aux_gnt, 1'b0);
            tick();
        end

        // First cycle after release: CPU read wins over the aux request
        rst       = 1'b1;
        cpu_wr_en = 4'h0;
        #3;
        checkFlag  ("release cpu_stall", cpu_stall, 1'b0);
        checkFlag  ("release aux_gnt", aux_gnt, 1'b0);
        checkOutput("release mem_addr", mem_addr, 32'h0000_0100);
        checkOutput("release mem_wr_en", 32'(mem_wr_en), 32'h0);
        tick();
        setIdle();
        mem_din = 32'h0BAD_F00D;
        #3;
        checkFlag  ("release cpu_rvalid", cpu_rvalid, 1'b1);
        checkFlag  ("release aux_rvalid", aux_rvalid, 1'b0);
        checkOutput("release cpu_rdata", cpu_rdata, 32'h0BAD_F00D);
        tick();

        // Table-driven single-cycle vectors
        for (int i = 0; i < NV; i++) begin
            applyStimulus(tbl[i]);
            #3;
            checkRow(i, tbl[i]);
            tick();
        end

        // Locked burst: one entry beat, then three beats under CPU pressure
        setIdle();
        aux_req  = 1'b1;
        aux_lock = 1'b1;
        aux_addr = 32'h0000_0300;
        #3;
        checkFlag  ("burst entry aux_gnt", aux_gnt, 1'b1);
        checkOutput("burst entry mem_addr", mem_addr, 32'h0000_0300);
        tick();
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0200;
        for (int b = 0; b < 3; b++) begin
            aux_addr = 32'h0000_0304 + 32'(4 * b);
            aux_lock = (b < 2);
            #3;
            checkFlag  ($sformatf("burst%0d cpu_stall", b), cpu_stall, 1'b1);
            checkFlag  ($sformatf("burst%0d aux_gnt", b), aux_gnt, 1'b1);
            checkOutput($sformatf("burst%0d mem_addr", b), mem_addr, 32'h0000_0304 + 32'(4 * b));
            checkFlag  ($sformatf("burst%0d aux_rvalid", b), aux_rvalid, 1'b1);
            tick();
        end
        aux_req  = 1'b0;
        aux_lock = 1'b0;
        #3;
        checkFlag  ("burst end cpu_stall", cpu_stall, 1'b0);
        checkOutput("burst end mem_addr", mem_addr, 32'h0000_0200);
        checkFlag  ("burst end aux_rvalid", aux_rvalid, 1'b1);
        checkFlag  ("burst end cpu_rvalid", cpu_rvalid, 1'b0);
        tick();
        setIdle();
        #3;
        checkFlag("burst tail cpu_rvalid", cpu_rvalid, 1'b1);
        checkFlag("burst tail aux_rvalid", aux_rvalid, 1'b0);
        tick();

        // Locked aux drops its request: CPU is granted in that same cycle
        aux_req  = 1'b1;
        aux_lock = 1'b1;
        aux_addr = 32'h0000_0700;
        #3;
        checkFlag("exit entry aux_gnt", aux_gnt, 1'b1);
        tick();
        aux_req  = 1'b0;
        aux_lock = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0710;
        #3;
        checkFlag  ("exit cpu_stall", cpu_stall, 1'b0);
        checkOutput("exit mem_addr", mem_addr, 32'h0000_0710);
        checkFlag  ("exit aux_rvalid", aux_rvalid, 1'b1);
        tick();
        cpu_addr = 32'h0000_0720;
        aux_req  = 1'b1;
        aux_addr = 32'h0000_0730;
        #3;
        checkFlag  ("exit back in cpu state aux_gnt", aux_gnt, 1'b0);
        checkOutput("exit back in cpu state mem_addr", mem_addr, 32'h0000_0720);
        checkFlag  ("exit cpu_rvalid", cpu_rvalid, 1'b1);
        tick();
        cpu_req = 1'b0;
        #3;
        checkFlag("exit aux catch-up aux_gnt", aux_gnt, 1'b1);
        tick();

        // Starvation under continuous CPU requests
        setIdle();
        cpu_req   = 1'b1;
        cpu_addr  = 32'h0000_0400;
        aux_req   = 1'b1;
        aux_addr  = 32'h0000_0500;
        aux_wr_en = 4'hF;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        for (int c = 1; c <= 10; c++) begin
            #3;
            checkFlag($sformatf("starve cycle%0d aux_gnt", c), aux_gnt, (c == 9));
            checkFlag($sformatf("starve cycle%0d cpu_stall", c), cpu_stall, (c == 9));
            if (c == 9) begin
                checkOutput("starve forced mem_wr_en", 32'(mem_wr_en), 32'hF);
                checkOutput("starve forced mem_addr", mem_addr, 32'h0000_0500);
            end
            tick();
        end
`else
        grants         = 0;
        stalls_missing = 0;
        for (int c = 0; c < 50; c++) begin
            #3;
            if (aux_gnt !== 1'b0) grants++;
            if (cpu_stall !== 1'b0) stalls_missing++;
            tick();
        end
        checkOutput("starve aux grants in 50 cycles", 32'(grants), 32'h0);
        checkOutput("starve cpu stalls in 50 cycles", 32'(stalls_missing), 32'h0);
`endif
        setIdle();
        tick();

        // Reset asserted mid-burst with an aux read outstanding
        aux_req  = 1'b1;
        aux_lock = 1'b1;
        aux_addr = 32'h0000_0800;
        #3;
        checkFlag("midrst entry aux_gnt", aux_gnt, 1'b1);
        tick();
        rst = 1'b0;
        #3;
        checkFlag  ("midrst aux_gnt", aux_gnt, 1'b0);
        checkOutput("midrst mem_wr_en", 32'(mem_wr_en), 32'h0);
        tick();
        rst      = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0600;
        #3;
        checkFlag  ("midrst after aux_rvalid", aux_rvalid, 1'b0);
        checkFlag  ("midrst after cpu_stall", cpu_stall, 1'b0);
        checkFlag  ("midrst after aux_gnt", aux_gnt, 1'b0);
        checkOutput("midrst after mem_addr", mem_addr, 32'h0000_0600);
        tick();
        setIdle();
        #3;
        checkFlag("midrst cpu_rvalid", cpu_rvalid, 1'b1);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
